// File: rtl/spi_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one SPI engine.
// It routes chip select to ROM or RAM and aborts any transaction that stalls too long.
module spi_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_done,
  output logic [7:0]  f_data,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [15:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic        d_done,
  output logic [7:0]  d_rdata,
  output logic        spi_start,
  output logic        spi_write,
  output logic [23:0] spi_addr,
  output logic [7:0]  spi_wdata,
  input  logic        spi_done,
  input  logic [7:0]  spi_rdata,
  output logic        sel_rom,
  output logic        sel_ram,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        grant_reg, grant_next;          // 0 = fetch, 1 = data
  logic        last_grant_reg, last_grant_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        f_done_reg, f_done_next;
  logic [7:0]  f_data_reg, f_data_next;
  logic        d_done_reg, d_done_next;
  logic [7:0]  d_rdata_reg, d_rdata_next;
  logic        start_reg, start_next;
  logic        write_reg, write_next;
  logic [23:0] addr_reg, addr_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic        sel_rom_reg, sel_rom_next;
  logic        sel_ram_reg, sel_ram_next;
  logic        terr_reg, terr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b0;
      cnt_reg        <= 8'd0;
      f_done_reg     <= 1'b0;
      f_data_reg     <= 8'd0;
      d_done_reg     <= 1'b0;
      d_rdata_reg    <= 8'd0;
      start_reg      <= 1'b0;
      write_reg      <= 1'b0;
      addr_reg       <= 24'd0;
      wdata_reg      <= 8'd0;
      sel_rom_reg    <= 1'b0;
      sel_ram_reg    <= 1'b0;
      terr_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      f_done_reg     <= f_done_next;
      f_data_reg     <= f_data_next;
      d_done_reg     <= d_done_next;
      d_rdata_reg    <= d_rdata_next;
      start_reg      <= start_next;
      write_reg      <= write_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      sel_rom_reg    <= sel_rom_next;
      sel_ram_reg    <= sel_ram_next;
      terr_reg       <= terr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    f_done_next     = 1'b0;
    f_data_next     = f_data_reg;
    d_done_next     = 1'b0;
    d_rdata_next    = d_rdata_reg;
    start_next      = start_reg;
    write_next      = write_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    sel_rom_next    = sel_rom_reg;
    sel_ram_next    = sel_ram_reg;
    terr_next       = terr_reg;

    case (state_reg)
      IDLE: begin
        if (f_req || d_req) begin
          // Contested requests alternate; otherwise the lone requester wins.
          grant_next      = (f_req && d_req) ? ~last_grant_reg : d_req;
          last_grant_next = grant_next;
          start_next      = 1'b1;
          if (grant_next) begin
            addr_next    = {8'h01, d_addr};
            write_next   = d_write;
            wdata_next   = d_wdata;
            sel_ram_next = 1'b1;
            sel_rom_next = 1'b0;
          end else begin
            addr_next    = {8'h00, f_addr};
            write_next   = 1'b0;
            sel_rom_next = 1'b1;
            sel_ram_next = 1'b0;
          end
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = 8'd0;
        state_next = WAIT;
      end
      WAIT: begin
        if (spi_done || cnt_reg == CNT_LAST) begin
          start_next   = 1'b0;
          sel_rom_next = 1'b0;
          sel_ram_next = 1'b0;
          state_next   = DONE;
          if (grant_reg) d_done_next = 1'b1;
          else           f_done_next = 1'b1;
          if (spi_done) begin
            if (!grant_reg)      f_data_next  = spi_rdata;
            else if (!write_reg) d_rdata_next = spi_rdata;
          end else begin
            terr_next = 1'b1;
            if (grant_reg) d_rdata_next = 8'hFF;
            else           f_data_next  = 8'hFF;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign f_done      = f_done_reg;
  assign f_data      = f_data_reg;
  assign d_done      = d_done_reg;
  assign d_rdata     = d_rdata_reg;
  assign spi_start   = start_reg;
  assign spi_write   = write_reg;
  assign spi_addr    = addr_reg;
  assign spi_wdata   = wdata_reg;
  assign sel_rom     = sel_rom_reg;
  assign sel_ram     = sel_ram_reg;
  assign timeout_err = terr_reg;

endmodule
